// File: rtl/desc_fetch.sv
// Segment descriptor fetch: validates a selector against the GDT/LDT limit,
// reads the 8-byte descriptor in two 32-bit beats and strobes it into slot 1 or 2.
module desc_fetch #(
    parameter bit NULL_FAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] selector,
    input  logic        target_2,
    input  logic        abort,
    input  logic [31:0] gdtr_base,
    input  logic [15:0] gdtr_limit,
    input  logic [31:0] ldtr_base,
    input  logic [31:0] ldtr_limit,
    input  logic        ldtr_valid,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_done,
    input  logic [31:0] rd_data,
    output logic        glob_descriptor_set,
    output logic        glob_descriptor_2_set,
    output logic [63:0] glob_descriptor_value,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        WRITE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        target_q, target_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] value_q, value_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;

    logic [12:0] sel_idx_s;
    logic        sel_ti_s;
    logic [31:0] limit_s;
    logic [31:0] base_s;
    logic [31:0] end_s;
    logic        unused_rpl_s;

    assign sel_idx_s    = selector[15:3];
    assign sel_ti_s     = selector[2];
    assign unused_rpl_s = ^selector[1:0];
    assign limit_s      = sel_ti_s ? ldtr_limit : {16'h0000, gdtr_limit};
    assign base_s       = sel_ti_s ? ldtr_base : gdtr_base;
    assign end_s        = {16'h0000, sel_idx_s, 3'b111};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0000_0000;
            target_q <= 1'b0;
            lo_q     <= 32'h0000_0000;
            value_q  <= 64'h0000_0000_0000_0000;
            fault_q  <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            lo_q     <= lo_d;
            value_q  <= value_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    // Next-state: selector checks in IDLE, two read beats, then one write cycle
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        lo_d     = lo_q;
        value_d  = value_q;
        fault_d  = 1'b0;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                // abort in the same cycle cancels the request before any check
                if (start && !abort) begin
                    if (NULL_FAULT && !sel_ti_s && (sel_idx_s == 13'd0)) begin
                        fault_d = 1'b1;
                        code_d  = 2'd1;
                    end else if (sel_ti_s && !ldtr_valid) begin
                        fault_d = 1'b1;
                        code_d  = 2'd2;
                    end else if (end_s > limit_s) begin
                        fault_d = 1'b1;
                        code_d  = 2'd3;
                    end else begin
                        addr_d   = base_s + {16'h0000, sel_idx_s, 3'b000};
                        target_d = target_2;
                        state_d  = RD_LO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_LO: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rd_done) begin
                    lo_d    = rd_data;
                    addr_d  = addr_q + 32'd4;
                    state_d = RD_HI;
                end else begin
                    state_d = RD_LO;
                end
            end
            RD_HI: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rd_done) begin
                    value_d = {rd_data, lo_q};
                    state_d = WRITE;
                end else begin
                    state_d = RD_HI;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_req                = (state_q == RD_LO) || (state_q == RD_HI);
    assign rd_addr               = addr_q;
    assign busy                  = (state_q != IDLE);
    assign done                  = (state_q == WRITE) && !abort;
    assign glob_descriptor_set   = done && !target_q;
    assign glob_descriptor_2_set = done && target_q;
    assign glob_descriptor_value = value_q;
    assign fault                 = fault_q;
    assign fault_code            = code_q;

endmodule
